// File: rtl/fifo_write_arbiter.sv
// Two-producer write arbiter in front of a FIFO: round-robin ownership with bounded bursts.
// Optional per-producer write statistics when FIFO_WRITE_ARBITER_STATS_EN is defined.
//
// state | meaning
// IDLE  | no owner, waiting for a request
// OWN0  | producer 0 owns the FIFO write port
// OWN1  | producer 1 owns the FIFO write port
module fifo_write_arbiter #(
  parameter int width     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [width-1:0] data0,
  input  logic             req1,
  input  logic [width-1:0] data1,
  input  logic             full,
  output logic             grant0,
  output logic             grant1,
  output logic             fifo_write,
  output logic [width-1:0] fifo_wdata,
  output logic             busy
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  ,
  output logic [7:0]       wr_count0,
  output logic [7:0]       wr_count1
`endif
);

  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_next;
  logic          last_served;
  logic [BW-1:0] burst_cnt;
  logic          last_beat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      burst_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next == OWN0 && state != OWN0)
        last_served <= 1'b0;
      else if (state_next == OWN1 && state != OWN1)
        last_served <= 1'b1;
      // Any change of owner (including release to IDLE) starts a fresh burst.
      if (state_next != state)
        burst_cnt <= '0;
      else if (grant0 | grant1)
        burst_cnt <= burst_cnt + BW'(1);
    end
  end

  assign last_beat = (grant0 | grant1) && (burst_cnt == LAST_BEAT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_next = last_served ? OWN0 : OWN1;
        else if (req0)
          state_next = OWN0;
        else if (req1)
          state_next = OWN1;
      end
      OWN0: begin
        // A full FIFO freezes ownership so stalled cycles never count against the burst.
        if (!full && (!req0 || last_beat))
          state_next = req1 ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!full && (!req1 || last_beat))
          state_next = req0 ? OWN0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant0     = (state == OWN0) && req0 && !full;
    grant1     = (state == OWN1) && req1 && !full;
    fifo_write = grant0 | grant1;
    fifo_wdata = '0;
    if (grant0)
      fifo_wdata = data0;
    else if (grant1)
      fifo_wdata = data1;
    busy = (state != IDLE);
  end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count0 <= '0;
      wr_count1 <= '0;
    end else begin
      if (grant0 && wr_count0 != 8'hFF)
        wr_count0 <= wr_count0 + 8'd1;
      if (grant1 && wr_count1 != 8'hFF)
        wr_count1 <= wr_count1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, latency, burst handover, stall, release, mid-burst reset.
// Statistics outputs are exercised when FIFO_WRITE_ARBITER_STATS_EN is defined.
module tb_fifo_write_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, full;
  logic [3:0] data0, data1;
  logic       grant0, grant1, fifo_write, busy;
  logic [3:0] fifo_wdata;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [7:0] wr_count0, wr_count1;
`endif

  int n_vec;
  int n_miscmp;

  fifo_write_arbiter #(.width(4), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .req1       (req1),
    .data1      (data1),
    .full       (full),
    .grant0     (grant0),
    .grant1     (grant1),
    .fifo_write (fifo_write),
    .fifo_wdata (fifo_wdata),
    .busy       (busy)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    .wr_count0  (wr_count0),
    .wr_count1  (wr_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Expected {grant1,grant0} and data for continuous contention, MAX_BURST=4.
  logic [1:0] exp_g[9]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
  logic [3:0] exp_wd[9] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'hC, 4'hC, 4'hC, 4'hC, 4'h5};

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    reset = 1'b0;
    req0 = 1'b1; data0 = 4'hA;
    req1 = 1'b0; data1 = 4'h0;
    full = 1'b0;

    // Outputs stay quiet while reset is held, even with a pending request.
    repeat (2) begin
      step();
      check("rst_grant0", grant0, 0);
      check("rst_grant1", grant1, 0);
      check("rst_write", fifo_write, 0);
      check("rst_wdata", fifo_wdata, 0);
      check("rst_busy", busy, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_grant0", grant0, 0);
    check("post_rst_busy", busy, 0);

    // Single producer: grant one cycle after the first edge.
    step();
    check("a_busy", busy, 1);
    check("a_grant0", grant0, 1);
    check("a_write", fifo_write, 1);
    check("a_wdata", fifo_wdata, 4'hA);
    step();
    req0 = 1'b0;
    #1;
    check("a_drop_grant0", grant0, 0);
    check("a_drop_write", fifo_write, 0);
    check("a_drop_wdata", fifo_wdata, 0);
    step();
    check("a_idle_busy", busy, 0);
    check("a_idle_write", fifo_write, 0);

    // Continuous contention: 4-beat bursts with no idle cycle at handover.
    req0 = 1'b1; data0 = 4'h5;
    req1 = 1'b1; data1 = 4'hC;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("b_grants_%0d", i), {grant1, grant0}, exp_g[i]);
      check($sformatf("b_write_%0d", i), fifo_write, 1);
      check($sformatf("b_wdata_%0d", i), fifo_wdata, exp_wd[i]);
    end

    // Producer 1 alone, stalled by full after two writes.
    req0 = 1'b0;
    req1 = 1'b1; data1 = 4'h3;
    pulse_reset();
    step();
    check("c_grant1_w1", grant1, 1);
    check("c_wdata", fifo_wdata, 4'h3);
    check("c_grant0", grant0, 0);
    step();
    check("c_grant1_w2", grant1, 1);
    step();
    full = 1'b1;
    #1;
    check("c_stall1_grant1", grant1, 0);
    check("c_stall1_write", fifo_write, 0);
    step();
    check("c_stall2_grant1", grant1, 0);
    check("c_stall2_busy", busy, 1);
    step();
    check("c_stall3_grant1", grant1, 0);
    check("c_stall3_busy", busy, 1);
    full = 1'b0;
    #1;
    check("c_grant1_w3", grant1, 1);
    step();
    check("c_grant1_w4", grant1, 1);
    step();
    check("c_release_busy", busy, 0);
    check("c_release_grant1", grant1, 0);

    // Reset mid-burst, then a tie goes to producer 0.
    step();
    check("d_grant1_pre", grant1, 1);
    reset = 1'b0;
    #1;
    check("d_rst_grant1", grant1, 0);
    check("d_rst_write", fifo_write, 0);
    check("d_rst_busy", busy, 0);
    req0 = 1'b1; data0 = 4'h9;
    @(negedge clk);
    reset = 1'b1;
    step();
    check("d_tie_grants", {grant1, grant0}, 2'b01);
    check("d_tie_wdata", fifo_wdata, 4'h9);

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    begin
      int writes;
      int cyc;
      req0 = 1'b1;
      req1 = 1'b0;
      pulse_reset();
      writes = 0;
      cyc = 0;
      while (writes < 300 && cyc < 1000) begin
        step();
        if (grant0) writes++;
        cyc++;
      end
      step();
      check("e_writes_done", writes, 300);
      req0 = 1'b0;
      step();
      check("e_wr_count0", wr_count0, 8'd255);
      check("e_wr_count1", wr_count1, 8'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
